button_press_decoder: RTL and testbench
=======================================

Name: button_press_decoder

Overview:
- Consumes the clean, synchronized level produced by the debounce stage and classifies each button gesture into single-cycle event pulses: press, release, short, long, double.
- Sits between the debounce stage and application logic (mode selection, menu control) in the button input path.
- Assumes a debounced input and performs no synchronization or filtering of its own.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- LONG_MS, 1000, hold time in ms that qualifies a press as long.
- DOUBLE_MS, 300, maximum gap in ms between release and second press for a double press.
- REPEAT_MS, 200, auto-repeat period in ms while a long press is held. Used only with REPEAT_EN.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- in  input  1  debounced button level, 1 = pressed.
- held  output  1  registered copy of in (previous-sample register).
- press  output  1  one-cycle pulse on a 0->1 transition of in.
- release  output  1  one-cycle pulse on a 1->0 transition of in.
- short_press  output  1  one-cycle pulse: single press, released before LONG, no second press within DOUBLE.
- long_press  output  1  one-cycle pulse when the hold reaches LONG.
- double_press  output  1  one-cycle pulse on the second press of a double.
- repeat_press  output  1  auto-repeat pulse (REPEAT_EN only; tied 0 otherwise).

Behaviour:
- Cycle constants: LongCycles = (CLK_HZ/1000)*LONG_MS, DoubleCycles = (CLK_HZ/1000)*DOUBLE_MS, RepeatCycles = (CLK_HZ/1000)*REPEAT_MS. All must be ≥ 2.
- Counter width: $clog2 of the largest cycle constant + 1. The counter saturates and never wraps.
- Reset values: all outputs 0, prev = 0, cnt = 0, state = IDLE.
- Reset is honoured mid-gesture; no event is emitted for an aborted gesture.
- If in = 1 when reset releases, press fires one cycle later and the gesture starts from there.
- Edge detection: rise = in & ~prev, fall = ~in & prev. prev <= in every cycle; held = prev.
- press/release: registered, asserted in the cycle after the sample that shows the change (latency 1). All event outputs have 1-cycle registered latency.
- FSM states:
  - IDLE: on rise -> DOWN1, cnt <= 0.
  - DOWN1: on fall -> WAIT2, cnt <= 0. Otherwise cnt++. When cnt == LongCycles-1, pulse long_press and go to LONG_HELD (cnt <= 0).
  - LONG_HELD: on fall -> IDLE. No further long_press pulses.
  - WAIT2: on rise, pulse double_press and go to DOWN2. Otherwise cnt++. When cnt == DoubleCycles-1, pulse short_press and go to IDLE.
  - DOWN2: on fall -> IDLE. Never emits long_press, whatever the hold length.
- Simultaneous events: an edge takes priority over a timeout in the same cycle.
  - Fall on the DOWN1 timeout cycle counts as a short (-> WAIT2, no long_press).
  - Rise on the WAIT2 timeout cycle counts as a double (no short_press).
- At most one of short/long/double/repeat is asserted in any cycle. press or release may coincide with double_press.
- short_press latency: DoubleCycles cycles after the release sample.

Optional Feature:
- Macro: BUTTON_DECODER_REPEAT_EN.
- Defined: in LONG_HELD, cnt counts. Every RepeatCycles cycles, repeat_press pulses for one cycle and cnt reloads to 0. The first repeat fires RepeatCycles after the long_press pulse. Pulses stop on fall.
- Undefined: repeat_press is a constant 0 and the REPEAT_MS parameter is ignored.

Decomposition:
- Package button_pkg:
  - state enum typedef btn_state_t {IDLE, DOWN1, LONG_HELD, WAIT2, DOWN2}.
  - function ms_to_cycles(clk_hz, ms), shared with the debounce stage.
- Sub-module edge_detect (clk, rst, in -> rise, fall, level): reusable, instantiated once.

Test Plan:
Bench parameters: CLK_HZ=10_000 (10 cycles/ms), LONG_MS=5 (50 cycles), DOUBLE_MS=3 (30 cycles), REPEAT_MS=2 (20 cycles).
1. Short press: in high 20 cycles, then low -> press, release, then short_press exactly 30 cycles after release. No other events.
2. Long press: in high 120 cycles -> long_press once, 50 cycles after the press sample. No short_press on release.
3. Double press: high 10, low 15, high 10 -> double_press with the second press pulse. No short_press or long_press.
4. Timeout boundary: release, then re-press on exactly the 30th WAIT2 cycle -> double_press, not short_press. A fall on the 50th DOWN1 cycle -> short path, no long_press.
5. Reset mid-hold: assert rst at cycle 30 of a press -> all outputs 0 immediately, no long_press. in still high after rst release -> press after 1 cycle, long_press 50 cycles later.
6. REPEAT_EN build: hold 120 cycles -> long_press at 50, repeat_press at 70, 90, 110, none after release. Non-REPEAT build: repeat_press constant 0.

Source files
------------

// File: rtl/button_press_decoder_pkg.sv
// Shared button-path types and helpers.
// Used by the decoder and the debounce stage.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DOWN1,
    LONG_HELD,
    WAIT2,
    DOWN2
  } btn_state_t;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/button_press_decoder_edge_detect.sv
// Registered previous-sample edge detector.
// rise/fall are combinational from the current sample.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise,
  output logic fall,
  output logic level
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= in;
  end

  assign rise  = in & ~prev;
  assign fall  = ~in & prev;
  assign level = prev;

endmodule

// File: rtl/button_press_decoder.sv
// Debounced button gesture decoder: press/release/short/long/double.
// Define BUTTON_DECODER_REPEAT_EN for auto-repeat while long-held.
module button_press_decoder
  import button_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int LONG_MS   = 1000,
  parameter int DOUBLE_MS = 300,
  parameter int REPEAT_MS = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic held,
  output logic press,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic repeat_press
);

  localparam int LongCycles   = ms_to_cycles(CLK_HZ, LONG_MS);
  localparam int DoubleCycles = ms_to_cycles(CLK_HZ, DOUBLE_MS);
  localparam int RepeatCycles = ms_to_cycles(CLK_HZ, REPEAT_MS);
  localparam int Max1 =
    (LongCycles > DoubleCycles) ? LongCycles : DoubleCycles;
  localparam int CntMax =
    (Max1 > RepeatCycles) ? Max1 : RepeatCycles;
  localparam int CW = $clog2(CntMax) + 1;

  localparam logic [CW-1:0] LongEnd   = CW'(LongCycles - 1);
  localparam logic [CW-1:0] DoubleEnd = CW'(DoubleCycles - 1);
`ifdef BUTTON_DECODER_REPEAT_EN
  localparam logic [CW-1:0] RepEnd    = CW'(RepeatCycles - 1);
`endif

  logic rise;
  logic fall;
  btn_state_t state;
  logic [CW-1:0] cnt;

  edge_detect u_edge (
    .clk   (clk),
    .rst   (rst),
    .in    (in),
    .rise  (rise),
    .fall  (fall),
    .level (held)
  );

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      double_press  <= 1'b0;
`ifdef BUTTON_DECODER_REPEAT_EN
      repeat_press  <= 1'b0;
`endif
    end else begin
      press         <= rise;
      release_pulse <= fall;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      double_press  <= 1'b0;
`ifdef BUTTON_DECODER_REPEAT_EN
      repeat_press  <= 1'b0;
`endif
      // Edges win over timeouts in the same cycle.
      unique case (state)
        IDLE: begin
          if (rise) begin
            state <= DOWN1;
            cnt   <= '0;
          end
        end
        DOWN1: begin
          if (fall) begin
            state <= WAIT2;
            cnt   <= '0;
          end else if (cnt == LongEnd) begin
            long_press <= 1'b1;
            state      <= LONG_HELD;
            cnt        <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        LONG_HELD: begin
          if (fall) begin
            state <= IDLE;
            cnt   <= '0;
`ifdef BUTTON_DECODER_REPEAT_EN
          end else if (cnt == RepEnd) begin
            repeat_press <= 1'b1;
            cnt          <= '0;
          end else begin
            cnt <= sat_inc(cnt);
`endif
          end
        end
        WAIT2: begin
          if (rise) begin
            double_press <= 1'b1;
            state        <= DOWN2;
            cnt          <= '0;
          end else if (cnt == DoubleEnd) begin
            short_press <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        DOWN2: begin
          if (fall) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifndef BUTTON_DECODER_REPEAT_EN
  assign repeat_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_press_decoder.sv
// Randomized + directed bench for button_press_decoder.
// Gesture model works on edge timestamps.
module tb_button_press_decoder;

  localparam int L = 50;
  localparam int D = 30;
  localparam int R = 20;
`ifdef BUTTON_DECODER_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk;
  logic rst;
  logic in;
  logic held, press, release_pulse, short_press;
  logic long_press, double_press, repeat_press;

  button_press_decoder #(
    .CLK_HZ(10_000), .LONG_MS(5), .DOUBLE_MS(3), .REPEAT_MS(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in            (in),
    .held          (held),
    .press         (press),
    .release_pulse (release_pulse),
    .short_press   (short_press),
    .long_press    (long_press),
    .double_press  (double_press),
    .repeat_press  (repeat_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: timestamps of the current gesture's first rise, first
  // fall and long qualification; -1 means not seen yet.
  int n = 0;
  int m_prev = 0;
  int t_rise1 = -1;
  int t_fall1 = -1;
  int t_long = -1;
  bit second = 0;
  logic [6:0] exp_o = '0;

  task automatic clear_gesture();
    t_rise1 = -1;
    t_fall1 = -1;
    t_long = -1;
    second = 0;
  endtask

  always @(posedge clk) begin
    bit r, f;
    bit e_s, e_l, e_d, e_r;
    if (rst) begin
      m_prev = 0;
      clear_gesture();
      exp_o = '0;
    end else begin
      n++;
      r = in & !m_prev[0];
      f = !in & m_prev[0];
      m_prev = int'(in);
      {e_s, e_l, e_d, e_r} = '0;
      if (t_rise1 < 0) begin
        if (r) t_rise1 = n;
      end else if (t_long >= 0) begin
        if (f) clear_gesture();
        else if (REP && ((n - t_long) % R == 0)) e_r = 1;
      end else if (second) begin
        if (f) clear_gesture();
      end else if (t_fall1 >= 0) begin
        if (r) begin
          e_d = 1;
          second = 1;
        end else if (n - t_fall1 == D) begin
          e_s = 1;
          clear_gesture();
        end
      end else begin
        if (f) t_fall1 = n;
        else if (n - t_rise1 == L) begin
          e_l = 1;
          t_long = n;
        end
      end
      exp_o = {in, r, f, e_s, e_l, e_d, e_r};
    end
  end

  wire [6:0] act_o = {held, press, release_pulse, short_press,
                      long_press, double_press, repeat_press};

  always @(negedge clk) begin
    if (rst) check("outputs_in_reset", int'(act_o), 0);
    else     check("outputs", int'(act_o), int'(exp_o));
    check("one_event", int'($countones(act_o[3:0]) <= 1), 1);
  end

  // Pulse log for literal timing checks.
  int ncyc = 0;
  int c_press, c_rel, c_short, c_long, c_dbl, c_rep;
  int y_press, y_rel, y_short, y_long, y_dbl, y_rep1, y_repn;

  always @(posedge clk) ncyc++;

  always @(negedge clk) begin
    if (press) begin c_press++; y_press = ncyc; end
    if (release_pulse) begin c_rel++; y_rel = ncyc; end
    if (short_press) begin c_short++; y_short = ncyc; end
    if (long_press) begin c_long++; y_long = ncyc; end
    if (double_press) begin c_dbl++; y_dbl = ncyc; end
    if (repeat_press) begin
      if (c_rep == 0) y_rep1 = ncyc;
      c_rep++;
      y_repn = ncyc;
    end
  end

  task automatic clr();
    {c_press, c_rel, c_short, c_long, c_dbl, c_rep} = '0;
    {y_press, y_rel, y_short, y_long, y_dbl, y_rep1, y_repn} = '0;
  endtask

  task automatic step(input logic v, input int k);
    in = v;
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_state", int'(act_o), 0);
    step(0, 5);

    clr(); step(1, 20); step(0, 40);
    check("t1_short_cnt", c_short, 1);
    check("t1_short_lat", y_short - y_rel, 30);
    check("t1_press_rel", c_press + c_rel, 2);
    check("t1_others", c_long + c_dbl + c_rep, 0);

    clr(); step(1, 120); step(0, 40);
    check("t2_long_cnt", c_long, 1);
    check("t2_long_lat", y_long - y_press, 50);
    check("t2_no_short", c_short, 0);
    check("t2_repeats", c_rep, REP ? 3 : 0);
    if (REP) begin
      check("t6_rep_first", y_rep1 - y_long, 20);
      check("t6_rep_last", y_repn - y_long, 60);
    end

    clr(); step(1, 10); step(0, 15); step(1, 10); step(0, 40);
    check("t3_dbl_cnt", c_dbl, 1);
    check("t3_dbl_with_press", y_dbl, y_press);
    check("t3_no_short_long", c_short + c_long, 0);

    clr(); step(1, 10); step(0, 30); step(1, 10); step(0, 40);
    check("t4_edge_dbl", c_dbl, 1);
    check("t4_edge_no_short", c_short, 0);

    clr(); step(1, 10); step(0, 31); step(1, 10); step(0, 40);
    check("t4_past_edge_short", c_short, 2);
    check("t4_past_edge_dbl", c_dbl, 0);

    clr(); step(1, 50); step(0, 40);
    check("t4_fall_on_timeout_short", c_short, 1);
    check("t4_fall_on_timeout_long", c_long, 0);

    clr(); step(1, 51); step(0, 40);
    check("t4_one_past_long", c_long, 1);
    check("t4_one_past_short", c_short, 0);

    clr(); step(1, 30);
    rst = 1'b1;
    #1 check("t5_rst_outputs", int'(act_o), 0);
    check("t5_no_long", c_long, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    clr(); step(1, 119); step(0, 40);
    check("t5_press_cnt", c_press, 1);
    check("t5_long_lat", y_long - y_press, 50);
    check("t5_long_cnt", c_long, 1);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end
      step(1'($urandom_range(0, 1)), $urandom_range(1, 70));
    end
    step(0, 40);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
